imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//  Upstream of the mini-CPU fetch stage: receives a framed byte stream from the
//  board UART receiver and writes 16-bit instruction words into instruction
//  memory (imem). Holds the CPU in reset while a program is being loaded.
//  Validates the frame with an 8-bit checksum and a per-byte timeout.
// PARAMETERS
//  ADDR_W          8          imem address width; depth = 2**ADDR_W words
//  DATA_W          16         instruction width; fixed 2 bytes per word
//  SYNC_BYTE       8'hA5      frame start marker
//  TIMEOUT_CYCLES  1_000_000  max clk cycles between bytes inside a frame
// PORTS
//  clk          in   1       single clock, all logic posedge
//  reset_n      in   1       asynchronous, active-low reset
//  rx_valid     in   1       one-cycle pulse: rx_data holds a received byte
//  rx_data      in   8       received byte
//  imem_we      out  1       one-cycle write strobe to imem
//  imem_addr    out  ADDR_W  write address
//  imem_wdata   out  DATA_W  write data {hi_byte, lo_byte}
//  cpu_hold     out  1       high: CPU must be held in reset
//  busy         out  1       high while a frame is in progress
//  load_done    out  1       one-cycle pulse on successful load
//  load_err     out  1       sticky error flag (checksum or timeout)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; counters, checksum cleared. Async assert,
//   takes effect immediately mid-frame; words already written stay in imem.
//  Frame: SYNC_BYTE, N, then N words as hi,lo byte pairs, then checksum byte.
//   N=0 means 2**ADDR_W words. Words go to addr 0,1,..,N-1 in order.
//   Checksum = 8-bit mod-256 sum of all data bytes (not SYNC, not N).
//  States: IDLE -> COUNT -> HI <-> LO -> CHECK -> IDLE.
//   IDLE : rx byte == SYNC_BYTE -> COUNT; set busy=1, cpu_hold=1, clear
//          load_err, clear sum/addr/timer. Any other byte ignored.
//   COUNT: latch N into word counter -> HI.
//   HI   : latch byte as hi, add to sum -> LO.
//   LO   : add to sum; next cycle imem_we=1 with addr/wdata (latency 1 clk
//          after the lo byte pulse); decrement word counter, addr+1;
//          counter reaches 0 -> CHECK, else -> HI.
//   CHECK: byte == sum -> load_done pulse next cycle, cpu_hold=0, busy=0;
//          mismatch -> load_err=1, cpu_hold stays 1, busy=0. -> IDLE.
//  Address: ADDR_W-bit; final write at addr N-1; never wraps to a second write.
//  Timeout: timer counts clk in any non-IDLE state, cleared on every rx_valid.
//   Reaching TIMEOUT_CYCLES -> load_err=1, busy=0, cpu_hold stays 1, -> IDLE.
//   rx_valid in the same cycle as expiry: byte wins, timer cleared.
//  SYNC_BYTE inside a frame is data, not a restart.
//  cpu_hold stays high after any error until a later frame succeeds.
//  rx_valid is honoured every clk; back-to-back pulses must be accepted.
// TESTING
//  1 A5 02 10 12 20 43 85 -> we@addr0=1012, we@addr1=2043, load_done pulse,
//    cpu_hold 1->0, load_err=0
//  2 Same frame, checksum 86 -> two writes occur, load_err=1, cpu_hold stays 1,
//    no load_done
//  3 A5 00 + 256 words + correct sum -> 256 writes, last addr FF, done pulse
//  4 A5 02 10 then idle TIMEOUT_CYCLES -> load_err=1, busy=0; then frame 1
//    -> load_err clears, done pulse, cpu_hold=0
//  5 Bytes 00 FF 5A in IDLE -> no imem_we, busy=0, cpu_hold unchanged
//  6 reset_n low mid-frame (after hi byte) -> all outputs 0 same cycle;
//    after release, frame 1 loads correctly

Source files
------------

// File: rtl/imem_loader_if.sv
// Bundles the UART byte stream, the imem write port and the loader status
// flags. master = the loader itself, slave = the surrounding system.
interface imem_loader_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              load_done;
  logic              load_err;

  modport master (
    input  rx_valid, rx_data,
    output imem_we, imem_addr, imem_wdata,
    output cpu_hold, busy, load_done, load_err
  );

  modport slave (
    output rx_valid, rx_data,
    input  imem_we, imem_addr, imem_wdata,
    input  cpu_hold, busy, load_done, load_err
  );
endinterface

// File: rtl/imem_loader.sv
// Program loader: turns a framed UART byte stream into imem word writes and
// keeps the CPU in reset until a frame with a good checksum has been loaded.
//
// state | meaning
// IDLE  | waiting for the sync byte; all other bytes are dropped
// COUNT | next byte is the word count N (0 means full depth)
// HI    | next byte is the high byte of a word
// LO    | next byte is the low byte; the word is written one clock later
// CHECK | next byte is the checksum over all data bytes
module imem_loader #(
  parameter int         ADDR_W         = 8,
  parameter int         DATA_W         = 16,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1_000_000
) (
  input logic           clk,
  input logic           reset_n,
  imem_loader_if.master bus
);

  // Word counter must hold both the 8-bit N byte and the full depth 2**ADDR_W.
  localparam int CNT_W = ((ADDR_W > 8) ? ADDR_W : 8) + 1;
  localparam logic [CNT_W-1:0] WORDS_MAX = CNT_W'(2 ** ADDR_W);
  localparam logic [CNT_W-1:0] ONE_WORD  = CNT_W'(1);

  // Inter-byte timer is a down-counter: reloaded on each byte, expiry when it
  // sits at zero with no byte arriving, i.e. TIMEOUT_CYCLES idle clocks.
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, COUNT, HI, LO, CHECK} state_t;

  state_t            state;
  logic [7:0]        hi_byte;
  logic [7:0]        sum;
  logic [ADDR_W-1:0] wr_addr;
  logic [CNT_W-1:0]  words_left;
  logic [TMR_W-1:0]  timer;

  // Frame FSM with registered outputs; a received byte always beats a
  // timeout that would expire in the same clock.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      hi_byte        <= '0;
      sum            <= '0;
      wr_addr        <= '0;
      words_left     <= '0;
      timer          <= '0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      bus.cpu_hold   <= 1'b0;
      bus.busy       <= 1'b0;
      bus.load_done  <= 1'b0;
      bus.load_err   <= 1'b0;
    end else begin
      bus.imem_we   <= 1'b0;
      bus.load_done <= 1'b0;

      if (state != IDLE) begin
        if (bus.rx_valid)
          timer <= TMR_LOAD;
        else if (timer != '0)
          timer <= timer - 1'b1;
      end

      if (bus.rx_valid) begin
        case (state)
          IDLE: begin
            if (bus.rx_data == SYNC_BYTE) begin
              state        <= COUNT;
              bus.busy     <= 1'b1;
              bus.cpu_hold <= 1'b1;
              bus.load_err <= 1'b0;
              sum          <= '0;
              wr_addr      <= '0;
              timer        <= TMR_LOAD;
            end
          end
          COUNT: begin
            words_left <= (bus.rx_data == 8'h00) ? WORDS_MAX : CNT_W'(bus.rx_data);
            state      <= HI;
          end
          HI: begin
            hi_byte <= bus.rx_data;
            sum     <= sum + bus.rx_data;
            state   <= LO;
          end
          LO: begin
            sum            <= sum + bus.rx_data;
            bus.imem_we    <= 1'b1;
            bus.imem_addr  <= wr_addr;
            bus.imem_wdata <= DATA_W'({hi_byte, bus.rx_data});
            // wr_addr may wrap after the last word; nothing writes with it.
            wr_addr        <= wr_addr + 1'b1;
            words_left     <= words_left - 1'b1;
            state          <= (words_left == ONE_WORD) ? CHECK : HI;
          end
          CHECK: begin
            if (bus.rx_data == sum) begin
              bus.load_done <= 1'b1;
              bus.cpu_hold  <= 1'b0;
            end else begin
              bus.load_err  <= 1'b1;
            end
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE && timer == '0) begin
        bus.load_err <= 1'b1;
        bus.busy     <= 1'b0;
        state        <= IDLE;
      end
    end
  end

endmodule
